// File: rtl/multdiv_sequencer.sv
// ----------------------------------------------------------------------------
// multdiv_sequencer
//   Iterative 32-bit signed multiply / divide unit. A start pulse latches the
//   operands, then one bit is processed per clock for 32 clocks: shift-add for
//   multiply, restoring division for divide. Both work on operand magnitudes
//   and apply the sign at the end. Results are presented in DONE with a
//   one-cycle resultRDY pulse.
//
// Ports
//   clock      in   1  rising-edge system clock
//   reset      in   1  synchronous active-high reset
//   ctrl_mult  in   1  start signed multiply (wins over ctrl_div)
//   ctrl_div   in   1  start signed divide
//   operandA   in  32  multiplicand / dividend
//   operandB   in  32  multiplier / divisor
//   result     out 32  product low word or quotient
//   exception  out  1  overflow or divide-by-zero
//   resultRDY  out  1  result/exception valid (one cycle)
//   busy       out  1  iteration in progress
// ----------------------------------------------------------------------------
module multdiv_sequencer (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_mult,
   input  logic        ctrl_div,
   input  logic [31:0] operandA,
   input  logic [31:0] operandB,
   output logic [31:0] result,
   output logic        exception,
   output logic        resultRDY,
   output logic        busy
);

   localparam int unsigned W  = 32;
   localparam int unsigned W2 = 2 * W;
   localparam int unsigned CW = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MULT = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W2-1:0]   acc_q, acc_d;      // mult: {partial hi, multiplier}; div: {remainder, quotient}
   logic [W-1:0]    opnd_q, opnd_d;    // |multiplicand| or |divisor|
   logic            neg_q, neg_d;      // result sign must be flipped
   logic            ovf_q, ovf_d;      // most-negative / -1 divide
   logic [W-1:0]    result_q, result_d;
   logic            exc_q, exc_d;
   logic            rdy_q, rdy_d;
   logic            busy_q, busy_d;

   logic            accept_c;
   logic            start_mult_c;
   logic            start_div_c;
   logic            div_zero_c;
   logic            last_c;
   logic [W-1:0]    mag_a_c;
   logic [W-1:0]    mag_b_c;
   logic [W:0]      mult_sum_c;
   logic [W2-1:0]   mult_step_c;
   logic [W:0]      div_sh_c;
   logic            div_ge_c;
   logic [W-1:0]    div_rem_c;
   logic [W2-1:0]   div_step_c;
   logic [W2-1:0]   prod_fin_c;
   logic [W:0]      prod_hi_c;
   logic [W-1:0]    quo_fin_c;

   // Start decode: only IDLE/DONE accept, multiply has priority
   always_comb begin
      accept_c     = ((state_q == S_IDLE) || (state_q == S_DONE)) && (ctrl_mult || ctrl_div);
      start_mult_c = accept_c && ctrl_mult;
      start_div_c  = accept_c && !ctrl_mult && ctrl_div;
      div_zero_c   = (operandB == '0);
      last_c       = (cnt_q == CW'(W - 1));
      mag_a_c      = operandA[W-1] ? W'(-operandA) : operandA;
      mag_b_c      = operandB[W-1] ? W'(-operandB) : operandB;
   end

   // One iteration of each algorithm, plus sign correction of the final step
   always_comb begin
      // shift-add: add multiplicand to upper half when multiplier LSB is set, then shift right
      mult_sum_c  = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mult_step_c = {mult_sum_c, acc_q[W-1:1]};

      // restoring: shift next dividend bit into remainder, subtract if it fits
      div_sh_c    = {acc_q[W2-1:W], acc_q[W-1]};
      div_ge_c    = (div_sh_c >= {1'b0, opnd_q});
      div_rem_c   = div_ge_c ? (div_sh_c[W-1:0] - opnd_q) : div_sh_c[W-1:0];
      div_step_c  = {div_rem_c, acc_q[W-2:0], div_ge_c};

      prod_fin_c  = neg_q ? W2'(-mult_step_c) : mult_step_c;
      prod_hi_c   = prod_fin_c[W2-1:W-1];
      quo_fin_c   = neg_q ? W'(-div_step_c[W-1:0]) : div_step_c[W-1:0];
   end

   // FSM state register and registered status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         rdy_q   <= rdy_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start_mult_c) begin
               state_d = S_MULT;
            end else if (start_div_c) begin
               state_d = div_zero_c ? S_DONE : S_DIV;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MULT: if (last_c) state_d = S_DONE;
         S_DIV:  if (last_c) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs, registered from the next state
   always_comb begin
      busy_d = 1'b0;
      rdy_d  = 1'b0;
      busy_d = (state_d == S_MULT) || (state_d == S_DIV);
      rdy_d  = (state_d == S_DONE);
   end

   // Datapath next values; result/exception change only when entering DONE
   always_comb begin
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      exc_d    = exc_q;

      if (start_mult_c) begin
         cnt_d  = '0;
         opnd_d = mag_a_c;
         acc_d  = {{W{1'b0}}, mag_b_c};
         neg_d  = operandA[W-1] ^ operandB[W-1];
         ovf_d  = 1'b0;
      end else if (start_div_c) begin
         cnt_d  = '0;
         opnd_d = mag_b_c;
         acc_d  = {{W{1'b0}}, mag_a_c};
         neg_d  = operandA[W-1] ^ operandB[W-1];
         // only 0x80000000 / -1 overflows; magnitude path still yields 0x80000000
         ovf_d  = (operandA == {1'b1, {(W-1){1'b0}}}) && (operandB == {W{1'b1}});
         if (div_zero_c) begin
            result_d = '0;
            exc_d    = 1'b1;
         end
      end else if (state_q == S_MULT) begin
         cnt_d = cnt_q + CW'(1);
         acc_d = mult_step_c;
         if (last_c) begin
            result_d = prod_fin_c[W-1:0];
            exc_d    = !((&prod_hi_c) || (~|prod_hi_c));
         end
      end else if (state_q == S_DIV) begin
         cnt_d = cnt_q + CW'(1);
         acc_d = div_step_c;
         if (last_c) begin
            result_d = quo_fin_c;
            exc_d    = ovf_q;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
         result_q <= result_d;
         exc_q    <= exc_d;
      end
   end

   assign result    = result_q;
   assign exception = exc_q;
   assign resultRDY = rdy_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// ----------------------------------------------------------------------------
// tb_multdiv_sequencer
//   Self-checking bench: directed vector table, hand-written multi-cycle
//   sequences (ignored start, mid-op reset, back-to-back start) and random
//   operations checked against a plain-arithmetic signed reference model.
// ----------------------------------------------------------------------------
module tb_multdiv_sequencer;

   logic        clock;
   logic        reset;
   logic        ctrl_mult;
   logic        ctrl_div;
   logic [31:0] operandA;
   logic [31:0] operandB;
   logic [31:0] result;
   logic        exception;
   logic        resultRDY;
   logic        busy;

   int nerr = 0;
   int nchk = 0;

   multdiv_sequencer dut (
      .clock     (clock),
      .reset     (reset),
      .ctrl_mult (ctrl_mult),
      .ctrl_div  (ctrl_div),
      .operandA  (operandA),
      .operandB  (operandB),
      .result    (result),
      .exception (exception),
      .resultRDY (resultRDY),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      bit          mult;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      bit          exc;
      int          lat;
   } vec_t;

   // advance one clock; inputs driven and outputs sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // signed reference: 64-bit product range check, truncating division
   function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output bit e);
      longint sa;
      longint sb;
      longint p;
      sa = $signed(a);
      sb = $signed(b);
      if (m) begin
         p = sa * sb;
         r = p[31:0];
         e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end else if (b == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else if (sa == -64'sd2147483648 && sb == -64'sd1) begin
         r = 32'h8000_0000;
         e = 1'b1;
      end else begin
         p = sa / sb;
         r = p[31:0];
         e = 1'b0;
      end
   endfunction

   task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
      ctrl_mult = m;
      ctrl_div  = d;
      operandA  = a;
      operandB  = b;
      tick();
      ctrl_mult = 1'b0;
      ctrl_div  = 1'b0;
   endtask

   // wait for resultRDY starting from cycle 'cyc0'; counts busy cycles on the way
   task automatic wait_rdy(input int cyc0, output int lat, output int busy_cnt);
      lat      = cyc0;
      busy_cnt = 0;
      while (!resultRDY && lat < 60) begin
         if (busy) busy_cnt++;
         tick();
         lat++;
      end
      if (busy) busy_cnt++;
   endtask

   task automatic run_op(input string name, input bit m, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input bit ee,
                         input int elat);
      int lat;
      int bc;
      start(m, !m, a, b);
      wait_rdy(1, lat, bc);
      chk({name, " latency"}, 64'(lat), 64'(elat));
      chk({name, " busy cycles"}, 64'(bc), (elat == 33) ? 64'd32 : 64'd0);
      chk({name, " result"}, 64'(result), 64'(er));
      chk({name, " exception"}, 64'(exception), 64'(ee));
      tick();
      chk({name, " rdy pulse width"}, 64'(resultRDY), 64'd0);
      chk({name, " busy after"}, 64'(busy), 64'd0);
   endtask

   task automatic count_rdy(input int ncyc, output int n);
      n = 0;
      for (int i = 0; i < ncyc; i++) begin
         if (resultRDY) n++;
         tick();
      end
   endtask

   vec_t vecs[13];

   initial begin
      int lat;
      int bc;
      int n;
      logic [31:0] er;
      bit ee;

      vecs[0]  = '{1'b1, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 33};
      vecs[1]  = '{1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 33};
      vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33};
      vecs[3]  = '{1'b0, 32'd100,        32'd0,         32'h0000_0000, 1'b1, 1};
      vecs[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};
      vecs[5]  = '{1'b0, 32'd1000,       32'd7,         32'd142,       1'b0, 33};
      vecs[6]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};
      vecs[7]  = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33};
      vecs[8]  = '{1'b0, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33};
      vecs[9]  = '{1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, 33};
      vecs[10] = '{1'b1, 32'd0,          32'h0001_2345, 32'h0000_0000, 1'b0, 33};
      vecs[11] = '{1'b1, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1, 33};
      vecs[12] = '{1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        1'b0, 33};

      reset     = 1'b1;
      ctrl_mult = 1'b0;
      ctrl_div  = 1'b0;
      operandA  = '0;
      operandB  = '0;
      tick();
      tick();
      chk("reset result", 64'(result), 64'd0);
      chk("reset exception", 64'(exception), 64'd0);
      chk("reset rdy", 64'(resultRDY), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      reset = 1'b0;
      tick();

      // directed table
      for (int i = 0; i < 13; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].mult, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].exc, vecs[i].lat);
      end

      // start during MULT is ignored
      start(1'b1, 1'b0, 32'd3, 32'd5);
      repeat (9) tick();
      ctrl_div = 1'b1;
      operandA = 32'd99;
      operandB = 32'd1;
      tick();
      ctrl_div = 1'b0;
      wait_rdy(11, lat, bc);
      chk("ignore latency", 64'(lat), 64'd33);
      chk("ignore result", 64'(result), 64'd15);
      tick();
      count_rdy(40, n);
      chk("ignore no second rdy", 64'(n), 64'd0);

      // reset in the middle of a divide
      start(1'b0, 1'b1, 32'd1000, 32'd7);
      repeat (14) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreset busy", 64'(busy), 64'd0);
      chk("midreset result", 64'(result), 64'd0);
      count_rdy(40, n);
      chk("midreset no rdy", 64'(n), 64'd0);
      run_op("after reset div", 1'b0, 32'd1000, 32'd7, 32'd142, 1'b0, 33);

      // reset wins over same-cycle start
      reset     = 1'b1;
      ctrl_mult = 1'b1;
      operandA  = 32'd2;
      operandB  = 32'd2;
      tick();
      reset     = 1'b0;
      ctrl_mult = 1'b0;
      chk("reset prio busy", 64'(busy), 64'd0);
      count_rdy(40, n);
      chk("reset prio no rdy", 64'(n), 64'd0);

      // both starts together: multiply wins
      start(1'b1, 1'b1, 32'd3, 32'd4);
      wait_rdy(1, lat, bc);
      chk("both latency", 64'(lat), 64'd33);
      chk("both result", 64'(result), 64'd12);

      // back-to-back start from DONE, result holds until next DONE
      start(1'b1, 1'b0, 32'd6, 32'd7);
      wait_rdy(1, lat, bc);
      chk("b2b first result", 64'(result), 64'd42);
      start(1'b0, 1'b1, 32'd100, 32'd3);
      chk("b2b busy no gap", 64'(busy), 64'd1);
      chk("b2b result held", 64'(result), 64'd42);
      wait_rdy(1, lat, bc);
      chk("b2b latency", 64'(lat), 64'd33);
      chk("b2b result", 64'(result), 64'd33);
      run_op("b2b divzero", 1'b0, 32'd5, 32'd0, 32'd0, 1'b1, 1);

      // random operations vs reference model
      for (int i = 0; i < 30; i++) begin
         bit m;
         logic [31:0] a;
         logic [31:0] b;
         int sel;
         m   = 1'($urandom % 2);
         a   = $urandom;
         b   = $urandom;
         sel = int'($urandom % 8);
         case (sel)
            0: b = 32'd0;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: begin
               a = ($urandom % 2) ? 32'($urandom % 64) : -32'($urandom % 64);
               b = ($urandom % 2) ? 32'($urandom % 64) : -32'($urandom % 64);
            end
            default: ;
         endcase
         model(m, a, b, er, ee);
         run_op($sformatf("rnd%0d %s %h %h", i, m ? "mul" : "div", a, b), m, a, b, er, ee,
                (!m && b == 32'd0) ? 1 : 33);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
